mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
Sequencer for the RV32M multiply path. It accepts the use_mult/mult_type request that EX decodes for MUL, MULH, MULHSU and MULHU. It runs an iterative shift-add multiplier over several cycles and stalls the pipeline while busy. It then returns the selected 32-bit half, rd address and rd write enable to the EX/MEM boundary.

Parameters:
BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; legal values are 1, 2, 4, 8. N_CALC = 32/BITS_PER_CYCLE.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid_i  in  1  EX holds an RV32M multiply (use_mult)
mult_type_i  in  2  MULT_TYPE_LOW32 / SxS_HIGH32 / SxU_HIGH32 / UxU_HIGH32
rs1_data_i  in  32  multiplicand
rs2_data_i  in  32  multiplier
rd_addr_i  in  5  destination register
rd_we_i  in  1  destination write enable
flush_i  in  1  kill the in-flight operation
stall_o  out  1  hold IF/ID/EX
busy_o  out  1  state != IDLE
result_valid_o  out  1  one-cycle result strobe
result_o  out  32  selected product half
rd_addr_o  out  5  latched rd_addr
rd_we_o  out  1  latched rd_we, qualified by result_valid_o

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset (rst=0, async) forces IDLE, clears all registers, and drives every output to 0.
- IDLE, req_valid_i=1, flush_i=0:
  - Latch operand magnitudes, the result sign, the type and the rd info.
  - Signedness: rs1 is signed for SxS and SxU. rs2 is signed for SxS only. LOW32 is treated as UxU.
  - Result sign = neg_a XOR neg_b.
  - Go to CALC with count=0 and a 64-bit accumulator of 0.
- CALC: each cycle adds BITS_PER_CYCLE partial products and shifts. count wraps at N_CALC-1, then go to FIX.
- FIX: negate the 64-bit accumulator if the sign is set. Select [31:0] for LOW32, else [63:32]. Register result_o, then go to DONE.
- DONE: result_valid_o=1 for exactly one cycle, then go to IDLE. req_valid_i is ignored in DONE, because the same instruction is still in EX.
- Latency: request first seen in cycle T gives result_valid_o in cycle T+N_CALC+2 (T+34 at default).
- stall_o is combinational: (IDLE & req_valid_i & ~flush_i) | CALC | FIX. It is low in DONE so the instruction leaves EX with its result.
- flush_i has priority in every state:
  - Next state is IDLE and result_valid_o is forced to 0 in the same cycle.
  - No partial result is ever emitted.
- Simultaneous flush_i and req_valid_i in IDLE: the request is not accepted.
- result_o and rd_addr_o hold their last value outside DONE. Consumers use them only under result_valid_o.
- Operand inputs are don't-care after acceptance.

Optional Feature:
MULT_PRODUCT_REUSE_EN
- Defined:
  - Keep a register set: cached rs1, cached rs2, cached type, 64-bit signed-corrected product, cache_valid.
  - A new accept hits the cache when cache_valid=1, both operands match, and (req type == LOW32 or req type == cached type).
  - On a hit, go IDLE→DONE directly; result_valid_o is at T+1 and stall_o is high for cycle T only.
  - The cache is filled on FIX completion only; a flushed op never fills it.
  - Reset clears cache_valid. A flush does not clear it.
- Undefined: no cache registers exist and every request takes the full latency.

Decomposition:
- defines.vh already holds the MULT_TYPE_* encodings.
- Add MULT_STATE_* encodings and MULT_ACC_WIDTH (64) to defines.vh.
- One sub-module, mult_shift_add_step: combinational BITS_PER_CYCLE-bit partial-product add/shift. The FSM and registers stay in mult_seq_ctrl.

Test Plan:
1. MUL, rs1=7, rs2=6, default params, req at T → stall_o high T..T+33, result_valid_o at T+34, result_o=0x0000002A, rd_addr_o echoes the input.
2. MULH 0x80000000×0x80000000 → 0x40000000. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
3. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
4. Cancel mid-operation:
   - Flush: flush_i at T+10 → IDLE at T+11, no result_valid_o, stall_o low.
   - Reset: rst low at T+5 → all outputs 0 immediately; a new MUL afterwards is correct.
5. Back-to-back: MUL then MULHU with no gap → second accepted the cycle after DONE, both results correct and in order. Repeat with BITS_PER_CYCLE=4, where latency is 10.
6. MULT_PRODUCT_REUSE_EN, MULHU 0xFFFFFFFF×0xFFFFFFFF then MUL with same operands → second result 0x00000001 at T+1. A following MULH with the same operands misses and takes the full latency.

Source files
------------

// File: rtl/mult_seq_ctrl_pkg.sv
// rtl/mult_seq_ctrl_pkg.sv - multiply type/state encodings and accumulator width for the RV32M sequencer
package mult_seq_ctrl_pkg;

  localparam logic [1:0] MULT_TYPE_LOW32      = 2'd0;
  localparam logic [1:0] MULT_TYPE_SXS_HIGH32 = 2'd1;
  localparam logic [1:0] MULT_TYPE_SXU_HIGH32 = 2'd2;
  localparam logic [1:0] MULT_TYPE_UXU_HIGH32 = 2'd3;

  localparam int MULT_ACC_WIDTH = 64;

  typedef enum logic [1:0] {
    MULT_STATE_IDLE = 2'd0,
    MULT_STATE_CALC = 2'd1,
    MULT_STATE_FIX  = 2'd2,
    MULT_STATE_DONE = 2'd3
  } mult_state_e;

  function automatic logic [31:0] mult_abs(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_shift_add_step.sv
// rtl/mult_shift_add_step.sv - one CALC cycle of the shift-add multiplier, BITS_PER_CYCLE partial products
module mult_shift_add_step
  import mult_seq_ctrl_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [MULT_ACC_WIDTH-1:0] acc,
  input  logic [MULT_ACC_WIDTH-1:0] mcand,
  input  logic [31:0]               mplier,
  output logic [MULT_ACC_WIDTH-1:0] acc_next,
  output logic [MULT_ACC_WIDTH-1:0] mcand_next,
  output logic [31:0]               mplier_next
);

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) begin
        acc_next = acc_next + (mcand << i);
      end
    end
  end

  assign mcand_next  = mcand << BITS_PER_CYCLE;
  assign mplier_next = mplier >> BITS_PER_CYCLE;

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - iterative RV32M multiply sequencer with pipeline stall and result strobe
// Optional product cache enabled by defining MULT_PRODUCT_REUSE_EN.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [1:0]  mult_type_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_we_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        result_valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_we_o
);

  localparam int N_CALC = 32 / BITS_PER_CYCLE;
  localparam int CNT_W  = $clog2(N_CALC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CALC - 1);

  mult_state_e state_q, state_d;
  logic [MULT_ACC_WIDTH-1:0] acc_q, mcand_q, acc_step, mcand_step, acc_fixed;
  logic [31:0] mplier_q, mplier_step, result_q, result_sel, hit_result;
  logic [CNT_W-1:0] count_q;
  logic [1:0] type_q;
  logic [4:0] rd_addr_q, rd_addr_out_q;
  logic sign_q, rd_we_q, rd_we_out_q;
  logic accept, neg_a, neg_b, hit;

  assign accept = (state_q == MULT_STATE_IDLE) && req_valid_i && !flush_i;
  assign neg_a  = rs1_data_i[31] && ((mult_type_i == MULT_TYPE_SXS_HIGH32) ||
                                     (mult_type_i == MULT_TYPE_SXU_HIGH32));
  assign neg_b  = rs2_data_i[31] && (mult_type_i == MULT_TYPE_SXS_HIGH32);

  assign acc_fixed  = sign_q ? (~acc_q + 64'd1) : acc_q;
  assign result_sel = (type_q == MULT_TYPE_LOW32) ? acc_fixed[31:0] : acc_fixed[63:32];

  mult_shift_add_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .acc         (acc_q),
    .mcand       (mcand_q),
    .mplier      (mplier_q),
    .acc_next    (acc_step),
    .mcand_next  (mcand_step),
    .mplier_next (mplier_step)
  );

`ifdef MULT_PRODUCT_REUSE_EN
  logic [31:0] op_rs1_q, op_rs2_q, c_rs1_q, c_rs2_q;
  logic [1:0]  c_type_q;
  logic [MULT_ACC_WIDTH-1:0] c_prod_q;
  logic        c_valid_q;

  // The low half is identical for every signedness, so LOW32 hits any cached type.
  assign hit = c_valid_q && (rs1_data_i == c_rs1_q) && (rs2_data_i == c_rs2_q) &&
               ((mult_type_i == MULT_TYPE_LOW32) || (mult_type_i == c_type_q));
  assign hit_result = (mult_type_i == MULT_TYPE_LOW32) ? c_prod_q[31:0] : c_prod_q[63:32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_rs1_q  <= '0;
      op_rs2_q  <= '0;
      c_rs1_q   <= '0;
      c_rs2_q   <= '0;
      c_type_q  <= '0;
      c_prod_q  <= '0;
      c_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        op_rs1_q <= rs1_data_i;
        op_rs2_q <= rs2_data_i;
      end
      if ((state_q == MULT_STATE_FIX) && !flush_i) begin
        c_rs1_q   <= op_rs1_q;
        c_rs2_q   <= op_rs2_q;
        c_type_q  <= type_q;
        c_prod_q  <= acc_fixed;
        c_valid_q <= 1'b1;
      end
    end
  end
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      MULT_STATE_IDLE: if (accept) state_d = hit ? MULT_STATE_DONE : MULT_STATE_CALC;
      MULT_STATE_CALC: if (count_q == CNT_LAST) state_d = MULT_STATE_FIX;
      MULT_STATE_FIX:  state_d = MULT_STATE_DONE;
      MULT_STATE_DONE: state_d = MULT_STATE_IDLE;
      default:         state_d = MULT_STATE_IDLE;
    endcase
    if (flush_i) state_d = MULT_STATE_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= MULT_STATE_IDLE;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      count_q       <= '0;
      sign_q        <= 1'b0;
      type_q        <= '0;
      rd_addr_q     <= '0;
      rd_we_q       <= 1'b0;
      result_q      <= '0;
      rd_addr_out_q <= '0;
      rd_we_out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q     <= '0;
        mcand_q   <= {32'd0, mult_abs(rs1_data_i, neg_a)};
        mplier_q  <= mult_abs(rs2_data_i, neg_b);
        count_q   <= '0;
        sign_q    <= neg_a ^ neg_b;
        type_q    <= mult_type_i;
        rd_addr_q <= rd_addr_i;
        rd_we_q   <= rd_we_i;
        if (hit) begin
          result_q      <= hit_result;
          rd_addr_out_q <= rd_addr_i;
          rd_we_out_q   <= rd_we_i;
        end
      end else if (state_q == MULT_STATE_CALC) begin
        acc_q    <= acc_step;
        mcand_q  <= mcand_step;
        mplier_q <= mplier_step;
        count_q  <= (count_q == CNT_LAST) ? '0 : count_q + CNT_W'(1);
      end else if ((state_q == MULT_STATE_FIX) && !flush_i) begin
        result_q      <= result_sel;
        rd_addr_out_q <= rd_addr_q;
        rd_we_out_q   <= rd_we_q;
      end
    end
  end

  // Gated by rst so a request held during reset cannot assert stall.
  assign stall_o        = rst && (accept || (state_q == MULT_STATE_CALC) || (state_q == MULT_STATE_FIX));
  assign busy_o         = (state_q != MULT_STATE_IDLE);
  assign result_valid_o = (state_q == MULT_STATE_DONE) && !flush_i;
  assign result_o       = result_q;
  assign rd_addr_o      = rd_addr_out_q;
  assign rd_we_o        = rd_we_out_q && result_valid_o;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - directed vector bench for mult_seq_ctrl (BITS_PER_CYCLE 1 and 4)
module tb_mult_seq_ctrl;
  import mult_seq_ctrl_pkg::*;

`ifdef MULT_PRODUCT_REUSE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 34;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, flush = 1'b0, rd_we = 1'b0;
  logic [1:0]  mult_type = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd_addr = '0;

  logic        stall1, busy1, rv1, we1, stall4, busy4, rv4, we4;
  logic [31:0] res1, res4;
  logic [4:0]  rda1, rda4;

  mult_seq_ctrl #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .mult_type_i(mult_type),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_addr_i(rd_addr), .rd_we_i(rd_we),
    .flush_i(flush), .stall_o(stall1), .busy_o(busy1), .result_valid_o(rv1),
    .result_o(res1), .rd_addr_o(rda1), .rd_we_o(we1)
  );

  mult_seq_ctrl #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .mult_type_i(mult_type),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_addr_i(rd_addr), .rd_we_i(rd_we),
    .flush_i(flush), .stall_o(stall4), .busy_o(busy4), .result_valid_o(rv4),
    .result_o(res4), .rd_addr_o(rda4), .rd_we_o(we4)
  );

  int dsel = 1;
  logic        o_stall, o_busy, o_rv, o_we;
  logic [31:0] o_res;
  logic [4:0]  o_rda;

  always_comb begin
    o_stall = stall1; o_busy = busy1; o_rv = rv1; o_we = we1; o_res = res1; o_rda = rda1;
    if (dsel == 4) begin
      o_stall = stall4; o_busy = busy4; o_rv = rv4; o_we = we4; o_res = res4; o_rda = rda4;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = 1'b0;
    flush = 1'b0;
    rst = 1'b0;
    step;
    step;
    rst = 1'b1;
    #1;
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, " stall"}, o_stall, 0);
    chk({nm, " busy"}, o_busy, 0);
    chk({nm, " result_valid"}, o_rv, 0);
    chk({nm, " result"}, o_res, 0);
    chk({nm, " rd_addr"}, o_rda, 0);
    chk({nm, " rd_we"}, o_we, 0);
  endtask

  // Latency is counted from the first cycle the request is visible to an IDLE sequencer.
  task automatic do_op(input string nm, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_lat, input bit keep);
    int lat;
    bit stall_ok;
    mult_type = t; rs1 = a; rs2 = b; rd_addr = rd; rd_we = (rd != 5'd0); req_valid = 1'b1;
    #1;
    if (o_rv) step;
    lat = 0;
    stall_ok = 1'b1;
    while (!o_rv && lat < 200) begin
      if (!o_stall) stall_ok = 1'b0;
      step;
      lat++;
    end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " stall while busy"}, stall_ok, 1);
    chk({nm, " stall in done"}, o_stall, 0);
    chk({nm, " result"}, o_res, exp);
    chk({nm, " rd_addr"}, o_rda, rd);
    chk({nm, " rd_we"}, o_we, (rd != 5'd0));
    if (!keep) req_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit seen;

    vecs[0]  = '{MULT_TYPE_LOW32,      32'd7,        32'd6,        5'd1,  32'h0000002A};
    vecs[1]  = '{MULT_TYPE_LOW32,      32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000001};
    vecs[2]  = '{MULT_TYPE_SXS_HIGH32, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000};
    vecs[3]  = '{MULT_TYPE_SXS_HIGH32, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000000};
    vecs[4]  = '{MULT_TYPE_SXU_HIGH32, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFF};
    vecs[5]  = '{MULT_TYPE_UXU_HIGH32, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE};
    vecs[6]  = '{MULT_TYPE_SXS_HIGH32, 32'h7FFFFFFF, 32'd2,        5'd7,  32'h00000000};
    vecs[7]  = '{MULT_TYPE_SXS_HIGH32, 32'hFFFFFFFE, 32'd3,        5'd8,  32'hFFFFFFFF};
    vecs[8]  = '{MULT_TYPE_LOW32,      32'h12345678, 32'h00000010, 5'd0,  32'h23456780};
    vecs[9]  = '{MULT_TYPE_UXU_HIGH32, 32'h80000000, 32'd4,        5'd31, 32'h00000002};
    vecs[10] = '{MULT_TYPE_SXU_HIGH32, 32'h80000000, 32'h80000000, 5'd9,  32'hC0000000};
    vecs[11] = '{MULT_TYPE_LOW32,      32'hFFFFFFFE, 32'd3,        5'd10, 32'hFFFFFFFA};

    #1;
    chk_idle_zero("reset");
    do_reset;

    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 34, 1'b0);
    end

    // flush in CALC
    do_reset;
    mult_type = MULT_TYPE_LOW32; rs1 = 32'd7; rs2 = 32'd6; rd_addr = 5'd5; rd_we = 1'b1; req_valid = 1'b1;
    #1;
    repeat (10) step;
    flush = 1'b1;
    #1;
    chk("flush calc result_valid", o_rv, 0);
    step;
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush calc busy after", o_busy, 0);
    chk("flush calc stall after", o_stall, 0);
    seen = 1'b0;
    repeat (40) begin
      if (o_rv) seen = 1'b1;
      step;
    end
    chk("flush calc no result", seen, 0);

    // flush with request in IDLE
    req_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush idle stall", o_stall, 0);
    step;
    chk("flush idle busy", o_busy, 0);
    flush = 1'b0; req_valid = 1'b0;

    // flush in DONE
    mult_type = MULT_TYPE_LOW32; rs1 = 32'd2; rs2 = 32'd3; rd_addr = 5'd12; rd_we = 1'b1; req_valid = 1'b1;
    #1;
    repeat (34) step;
    flush = 1'b1;
    #1;
    chk("flush done result_valid", o_rv, 0);
    chk("flush done rd_we", o_we, 0);
    step;
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush done busy after", o_busy, 0);

    // reset mid operation
    mult_type = MULT_TYPE_LOW32; rs1 = 32'h1234; rs2 = 32'd2; rd_addr = 5'd9; rd_we = 1'b1; req_valid = 1'b1;
    #1;
    repeat (5) step;
    rst = 1'b0;
    #1;
    chk_idle_zero("mid reset");
    rst = 1'b1;
    do_op("after reset", MULT_TYPE_LOW32, 32'd3, 32'd5, 5'd11, 32'd15, 34, 1'b0);

    // back-to-back, BITS_PER_CYCLE=1 then 4
    do_reset;
    do_op("b2b1 mul", MULT_TYPE_LOW32, 32'h1234, 32'h10, 5'd3, 32'h00012340, 34, 1'b1);
    do_op("b2b1 mulhu", MULT_TYPE_UXU_HIGH32, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 34, 1'b0);
    do_reset;
    dsel = 4;
    #1;
    do_op("b2b4 mul", MULT_TYPE_LOW32, 32'h1234, 32'h10, 5'd3, 32'h00012340, 10, 1'b1);
    do_op("b2b4 mulhu", MULT_TYPE_UXU_HIGH32, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 10, 1'b0);
    do_op("b2b4 mulhsu", MULT_TYPE_SXU_HIGH32, 32'h80000000, 32'h80000000, 5'd6, 32'hC0000000, 10, 1'b0);
    dsel = 1;
    #1;

    // product reuse sequence
    do_reset;
    do_op("reuse mulhu", MULT_TYPE_UXU_HIGH32, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, 34, 1'b0);
    do_op("reuse mul", MULT_TYPE_LOW32, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'h00000001, HIT_LAT, 1'b0);
    do_op("reuse mulh", MULT_TYPE_SXS_HIGH32, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'h00000000, 34, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
